// File: rtl/fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// fifo_burst_reader
//
// Drain stage for a 16-bit x 32-entry synchronous FIFO. It watches the FIFO
// fill level, pops words in bursts of BURST_LEN and presents them on a
// valid/ready stream, marking the final word of every burst with m_last.
// A level-sensitive flush, seen while idle, drains a partial burst (fewer
// than BURST_LEN words).
//
// Ports
//   clk           in   clock, all logic on posedge
//   reset         in   asynchronous reset, active-high
//   fifo_empty    in   FIFO empty flag
//   fifo_full     in   FIFO full flag (occupancy counter wraps to 0 when full)
//   fifo_counter  in   FIFO occupancy
//   fifo_data     in   FIFO read data; holds the word being popped while
//                      fifo_read is high and is captured on the next edge
//   fifo_read     out  registered FIFO pop strobe
//   flush         in   drain a partial burst when idle
//   m_valid       out  output word valid
//   m_ready       in   consumer ready
//   m_data        out  output word
//   m_last        out  final word of the current burst
//   busy          out  1 whenever the FSM is not idle
//   dbg_state     out  raw FSM state for debug and checkers
//
// Handshake: a word transfers on every posedge where m_valid && m_ready.
// Once m_valid is high it stays high, with m_data/m_last frozen, until that
// transfer happens; m_valid never depends combinationally on m_ready.
// ----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5,
  parameter int FIFO_DEPTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic [CNT_WIDTH-1:0]  fifo_counter,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // One extra bit so that a full FIFO (counter wrapped to 0) reads as DEPTH.
  localparam int OCC_W = CNT_WIDTH + 1;

  localparam logic [OCC_W-1:0] BURST_N = OCC_W'(BURST_LEN);
  localparam logic [OCC_W-1:0] DEPTH_N = OCC_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]            state_q,    state_d;
  logic [OCC_W-1:0]      n_q,        n_d;       // words in the current burst
  logic [OCC_W-1:0]      issued_q,   issued_d;  // pops issued in this burst
  logic                  rd_q,       rd_d;      // registered fifo_read
  logic                  infl_last_q, infl_last_d; // m_last tag of word in flight

  // 2-entry skid buffer between the FIFO read port and the stream
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic                  buf_last_q [2];
  logic                  buf_wr_ptr_q;
  logic                  buf_rd_ptr_q;
  logic [1:0]            buf_cnt_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [OCC_W-1:0] occ;
  logic             fire;
  logic [2:0]       pend;
  logic             room;
  logic             pop;
  logic             pop_last;

  assign occ  = fifo_full ? DEPTH_N : {1'b0, fifo_counter};
  assign fire = m_valid && m_ready;

  // Words owned by this block after this edge: buffered + the one in flight,
  // minus the one leaving now. Counting the departure lets the buffer sit at
  // one entry with a pop every cycle, which is what sustains full rate.
  assign pend = {1'b0, buf_cnt_q} + {2'b00, rd_q};
  assign room = (pend - {2'b00, fire}) < 3'd2;

  // The FIFO drops the word in flight at this edge, so a further pop needs at
  // least one more word than the one already being read.
  assign pop = (state_q == ST_BURST) && (issued_q < n_q) && !fifo_empty &&
               (occ > {{(OCC_W-1){1'b0}}, rd_q}) && room;

  assign pop_last = (issued_q == (n_q - {{(OCC_W-1){1'b0}}, 1'b1}));

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    issued_d    = issued_q;
    rd_d        = 1'b0;
    infl_last_d = infl_last_q;

    case (state_q)
      ST_IDLE: begin
        // Threshold start wins over flush; flush only covers a partial burst.
        if (occ >= BURST_N) begin
          state_d  = ST_BURST;
          n_d      = BURST_N;
          issued_d = '0;
        end else if (flush && !fifo_empty && (occ != '0)) begin
          state_d  = ST_BURST;
          n_d      = occ;
          issued_d = '0;
        end
      end

      ST_BURST: begin
        if (pop) begin
          rd_d        = 1'b1;
          infl_last_d = pop_last;
          issued_d    = issued_q + {{(OCC_W-1){1'b0}}, 1'b1};
          if (pop_last) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Only the burst's final word carries m_last, so its acceptance ends it.
        if (fire && m_last) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      issued_q    <= '0;
      rd_q        <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      issued_q    <= issued_d;
      rd_q        <= rd_d;
      infl_last_q <= infl_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Skid buffer: the word popped while rd_q is high is captured at the next
  // edge; head is read out when the consumer accepts it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
      buf_wr_ptr_q  <= 1'b0;
      buf_rd_ptr_q  <= 1'b0;
      buf_cnt_q     <= 2'd0;
    end else begin
      if (rd_q) begin
        buf_data_q[buf_wr_ptr_q] <= fifo_data;
        buf_last_q[buf_wr_ptr_q] <= infl_last_q;
        buf_wr_ptr_q             <= ~buf_wr_ptr_q;
      end
      if (fire) begin
        buf_rd_ptr_q <= ~buf_rd_ptr_q;
      end
      // Simultaneous write and read leave the count unchanged.
      case ({rd_q, fire})
        2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
        2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
        default: buf_cnt_q <= buf_cnt_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fifo_read = rd_q;
  assign m_valid   = (buf_cnt_q != 2'd0);
  assign m_data    = buf_data_q[buf_rd_ptr_q];
  // The head slot may hold a stale tag once drained, so qualify with valid.
  assign m_last    = m_valid && buf_last_q[buf_rd_ptr_q];
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Drives fifo_burst_reader from a behavioural 16x32 FIFO and checks the output
// stream against a reference built from the burst rules: every complete group
// of BURST_LEN written words leaves as one burst with m_last on its final word,
// and a flush while idle sends the remainder as one short burst.
// ----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int DW    = 16;
  localparam int CW    = 5;
  localparam int DEPTH = 32;
  localparam int BLEN  = 8;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fifo_rst = 1'b0;

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // DUT wiring
  // --------------------------------------------------------------------------
  logic          fifo_empty, fifo_full, fifo_read;
  logic [CW-1:0] fifo_counter;
  logic [DW-1:0] fifo_data;
  logic          flush = 1'b0;
  logic          m_valid, m_ready = 1'b0, m_last, busy;
  logic [DW-1:0] m_data;
  logic [1:0]    dbg_state;

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .FIFO_DEPTH (DEPTH),
    .BURST_LEN  (BLEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_counter (fifo_counter),
    .fifo_data    (fifo_data),
    .fifo_read    (fifo_read),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // --------------------------------------------------------------------------
  // Upstream FIFO model (head word shown on fifo_data, popped on the edge)
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  logic [4:0]    wp, rp;
  logic [5:0]    cnt;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  assign fifo_counter = cnt[4:0];
  assign fifo_full    = (cnt == 6'd32);
  assign fifo_empty   = (cnt == 6'd0);
  assign fifo_data    = mem[rp];

  always @(posedge clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp      <= wp + 5'd1;
      end
      if (fifo_read && cnt != 6'd0) rp <= rp + 5'd1;
      cnt <= cnt + {5'd0, wr_en} - {5'd0, (fifo_read && cnt != 6'd0)};
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  logic [DW:0]   exp_q[$];       // {last, data} in acceptance order
  logic [DW-1:0] model_fifo[$];  // written words not yet assigned to a burst
  logic [DW-1:0] wr_q[$];        // words waiting to be written

  int vectors = 0;
  int errs    = 0;
  int ready_mode = 0;            // 0 always, 1 random, 2 toggle, 3 stalled

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  // --------------------------------------------------------------------------
  // Per-cycle monitor
  // --------------------------------------------------------------------------
  int            cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            run = 0, max_run = 0;
  logic          stall_win = 1'b0;
  int            stall_pops = 0;
  logic          lat_arm = 1'b0;
  int            t_thr = -1, t_val = -1;

  always @(negedge clk) begin
    logic [DW:0] e;
    cyc++;
    if (reset || fifo_rst) begin
      prev_stall = 1'b0;
      run        = 0;
    end else begin
      chk("read_while_empty", {31'd0, fifo_read && fifo_empty}, 32'd0);
      if (prev_stall) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data",  {16'd0, m_data},  {16'd0, prev_data});
        chk("stall_last",  {31'd0, m_last},  {31'd0, prev_last});
      end
      if (m_valid && m_ready) begin
        chk("extra_word", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("data", {16'd0, m_data}, {16'd0, e[DW-1:0]});
          chk("last", {31'd0, m_last}, {31'd0, e[DW]});
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (fifo_read) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (stall_win && fifo_read) stall_pops++;
      if (lat_arm) begin
        if (t_thr < 0 && fifo_counter >= 5'(BLEN)) t_thr = cyc;
        if (t_val < 0 && m_valid) t_val = cyc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      2:       m_ready = ~m_ready;
      default: m_ready = 1'b0;
    endcase
    if (wr_q.size() > 0 && cnt < 6'd32) begin
      wr_en   = 1'b1;
      wr_data = wr_q.pop_front();
    end else begin
      wr_en = 1'b0;
    end
  endtask

  // Every complete group of BLEN written words becomes one burst.
  task automatic plan();
    logic [DW-1:0] d;
    while (model_fifo.size() >= BLEN) begin
      for (int j = 0; j < BLEN; j++) begin
        d = model_fifo.pop_front();
        exp_q.push_back({(j == BLEN - 1), d});
      end
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_q.push_back(d);
    model_fifo.push_back(d);
  endtask

  task automatic write_rand(input int k);
    for (int j = 0; j < k; j++) write_word(16'($urandom));
    plan();
  endtask

  // Whatever is left forms a single short burst ending in m_last.
  task automatic do_flush();
    logic [DW-1:0] d;
    while (model_fifo.size() > 0) begin
      d = model_fifo.pop_front();
      exp_q.push_back({(model_fifo.size() == 0), d});
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i = 0;
    while (i < budget && !(wr_q.size() == 0 && exp_q.size() == 0 && !busy &&
                           cnt < 6'(BLEN) && !fifo_read && !wr_en)) begin
      step();
      i++;
    end
    chk({tag, "_drain_timeout"}, {31'd0, i < budget}, 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int i;

    // Reset values
    #1;
    reset    = 1'b1;
    fifo_rst = 1'b1;
    #2;
    chk("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
    chk("rst_m_valid",   {31'd0, m_valid},   32'd0);
    chk("rst_m_last",    {31'd0, m_last},    32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_m_data",    {16'd0, m_data},    32'd0);
    step();
    step();
    reset    = 1'b0;
    fifo_rst = 1'b0;
    step();

    // 1: one full burst of 0..7, first-word latency and unbroken pops
    ready_mode = 0;
    t_thr = -1;
    t_val = -1;
    max_run = 0;
    lat_arm = 1'b1;
    for (int j = 0; j < 8; j++) write_word(16'(j));
    plan();
    wait_drain("t1", 200);
    lat_arm = 1'b0;
    chk("t1_first_word_latency", 32'(t_val - t_thr), 32'd3);
    chk("t1_read_run", 32'(max_run), 32'd8);

    // 2: 20 words -> two bursts, four words left behind
    for (int j = 0; j < 20; j++) write_word(16'(j));
    plan();
    wait_drain("t2", 300);
    chk("t2_counter", {27'd0, fifo_counter}, 32'd4);
    chk("t2_busy", {31'd0, busy}, 32'd0);

    // 3: flush drains the remaining four
    do_flush();
    wait_drain("t3", 200);
    chk("t3_empty", {31'd0, fifo_empty}, 32'd1);

    // 4: FIFO fills to full while the reader is held, then drains under 1010
    reset = 1'b1;
    write_rand(32);
    i = 0;
    while ((wr_q.size() > 0 || wr_en) && i < 200) begin
      step();
      i++;
    end
    chk("t4_full", {31'd0, fifo_full}, 32'd1);
    step();
    reset = 1'b0;
    ready_mode = 2;
    wait_drain("t4", 600);
    chk("t4_empty", {31'd0, fifo_empty}, 32'd1);

    // 5: ten-cycle consumer stall in the middle of a burst
    ready_mode = 0;
    write_rand(16);
    i = 0;
    while (exp_q.size() > 12 && i < 200) begin
      step();
      i++;
    end
    chk("t5_reach_mid_burst", {31'd0, i < 200}, 32'd1);
    ready_mode = 3;
    step();
    stall_pops = 0;
    stall_win  = 1'b1;
    for (int j = 0; j < 10; j++) step();
    stall_win = 1'b0;
    chk("t5_pops_during_stall", {31'd0, stall_pops <= 2}, 32'd1);
    ready_mode = 1;
    wait_drain("t5", 400);

    // 6: reset while the fourth word is on the bus
    ready_mode = 0;
    write_rand(8);
    i = 0;
    while (exp_q.size() > 5 && i < 200) begin
      step();
      i++;
    end
    reset    = 1'b1;
    fifo_rst = 1'b1;
    #1;
    chk("t6_m_valid",   {31'd0, m_valid},   32'd0);
    chk("t6_busy",      {31'd0, busy},      32'd0);
    chk("t6_fifo_read", {31'd0, fifo_read}, 32'd0);
    chk("t6_m_last",    {31'd0, m_last},    32'd0);
    exp_q.delete();
    model_fifo.delete();
    wr_q.delete();
    step();
    step();
    reset    = 1'b0;
    fifo_rst = 1'b0;
    write_rand(8);
    wait_drain("t6", 200);

    // Single-word flush burst: m_last on its only word
    write_rand(9);
    wait_drain("t7a", 300);
    chk("t7_one_left", {27'd0, fifo_counter}, 32'd1);
    do_flush();
    wait_drain("t7b", 200);

    // Random batches with random consumer readiness and flushes
    for (int r = 0; r < 6; r++) begin
      ready_mode = $urandom_range(0, 1);
      write_rand($urandom_range(1, 30));
      wait_drain("rnd", 800);
      if (model_fifo.size() > 0) begin
        do_flush();
        wait_drain("rnd_flush", 400);
      end
      chk("rnd_empty", {31'd0, fifo_empty}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
